// File: rtl/alu_regfile_seq.sv
// alu_regfile_seq: register file, 8-op ALU with carry/zero flags, and a
// four-state sequencer that runs one command per valid/ready transaction.
module alu_regfile_seq #(
  parameter int unsigned BIT_WIDTH = 8,
  parameter int unsigned NUM_REGS  = 4,
  localparam int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [2:0]           cmd_op,
  input  logic [ADDR_W-1:0]    cmd_rd,
  input  logic [ADDR_W-1:0]    cmd_ra,
  input  logic [ADDR_W-1:0]    cmd_rb,
  input  logic [BIT_WIDTH-1:0] cmd_imm,
  output logic                 res_valid,
  output logic [BIT_WIDTH-1:0] res_data,
  output logic                 carry,
  output logic                 zero,
  input  logic [ADDR_W-1:0]    dbg_addr,
  output logic [BIT_WIDTH-1:0] dbg_data
);

  localparam int unsigned SUM_W = BIT_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    OP_LOAD = 3'd0,
    OP_ADD  = 3'd1,
    OP_SUB  = 3'd2,
    OP_ADC  = 3'd3,
    OP_AND  = 3'd4,
    OP_OR   = 3'd5,
    OP_XOR  = 3'd6,
    OP_SHL  = 3'd7
  } op_e;

  state_e                 state_q, state_d;
  op_e                    op_q;
  logic [ADDR_W-1:0]      rd_q, ra_q, rb_q;
  logic [BIT_WIDTH-1:0]   imm_q;
  logic [BIT_WIDTH-1:0]   opa_q, opb_q;
  logic [BIT_WIDTH-1:0]   res_data_q;
  logic                   carry_q, zero_q, res_valid_q, cmd_ready_q;
  logic [BIT_WIDTH-1:0]   rf_q [NUM_REGS];

  logic                   accept, rd_en, ex_en, wb_en;
  logic [BIT_WIDTH-1:0]   alu_res;
  logic                   alu_carry;
  logic [SUM_W-1:0]       sum;

  // Sequencer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode and per-phase enables
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    rd_en   = 1'b0;
    ex_en   = 1'b0;
    wb_en   = 1'b0;
    case (state_q)
      ST_IDLE: if (cmd_valid) begin
        accept  = 1'b1;
        state_d = ST_READ;
      end
      ST_READ: begin
        rd_en   = 1'b1;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        ex_en   = 1'b1;
        state_d = ST_WB;
      end
      ST_WB: begin
        wb_en   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ALU: arithmetic at BIT_WIDTH+1 bits so the top bit is the carry/borrow
  always_comb begin
    sum       = '0;
    alu_res   = '0;
    alu_carry = carry_q;
    case (op_q)
      OP_LOAD: alu_res = imm_q;
      OP_ADD: begin
        sum       = {1'b0, opa_q} + {1'b0, opb_q};
        alu_res   = sum[BIT_WIDTH-1:0];
        alu_carry = sum[BIT_WIDTH];
      end
      OP_SUB: begin
        sum       = {1'b0, opa_q} - {1'b0, opb_q};
        alu_res   = sum[BIT_WIDTH-1:0];
        alu_carry = ~sum[BIT_WIDTH];
      end
      OP_ADC: begin
        sum       = {1'b0, opa_q} + {1'b0, opb_q} + SUM_W'(carry_q);
        alu_res   = sum[BIT_WIDTH-1:0];
        alu_carry = sum[BIT_WIDTH];
      end
      OP_AND: alu_res = opa_q & opb_q;
      OP_OR:  alu_res = opa_q | opb_q;
      OP_XOR: alu_res = opa_q ^ opb_q;
      OP_SHL: begin
        alu_res   = {opa_q[BIT_WIDTH-2:0], 1'b0};
        alu_carry = opa_q[BIT_WIDTH-1];
      end
      default: alu_res = '0;
    endcase
  end

  // Command capture, operand snapshot, result/flag registers and handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q        <= OP_LOAD;
      rd_q        <= '0;
      ra_q        <= '0;
      rb_q        <= '0;
      imm_q       <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      res_data_q  <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      res_valid_q <= 1'b0;
      cmd_ready_q <= 1'b1;
    end else begin
      cmd_ready_q <= (state_d == ST_IDLE);
      res_valid_q <= ex_en;
      if (accept) begin
        op_q  <= op_e'(cmd_op);
        rd_q  <= cmd_rd;
        ra_q  <= cmd_ra;
        rb_q  <= cmd_rb;
        imm_q <= cmd_imm;
      end
      if (rd_en) begin
        opa_q <= rf_q[ra_q];
        opb_q <= rf_q[rb_q];
      end
      if (ex_en) begin
        res_data_q <= alu_res;
        carry_q    <= alu_carry;
        zero_q     <= (alu_res == '0);
      end
    end
  end

  // Register file: single write port used only in write-back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rf_q <= '{default: '0};
    else if (wb_en) rf_q[rd_q] <= res_data_q;
  end

  assign cmd_ready = cmd_ready_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign dbg_data  = rf_q[dbg_addr];

endmodule

// File: tb/tb_alu_regfile_seq.sv
// Directed bench for alu_regfile_seq: vector table plus handshake and reset corner cases.
module tb_alu_regfile_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [1:0] cmd_rd, cmd_ra, cmd_rb;
  logic [7:0] cmd_imm;
  logic       res_valid;
  logic [7:0] res_data;
  logic       carry, zero;
  logic [1:0] dbg_addr;
  logic [7:0] dbg_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] op;
    logic [1:0] rd, ra, rb;
    logic [7:0] imm;
    logic [7:0] res;
    logic       c, z;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  alu_regfile_seq #(.BIT_WIDTH(8), .NUM_REGS(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb),
    .cmd_imm(cmd_imm),
    .res_valid(res_valid), .res_data(res_data), .carry(carry), .zero(zero),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] op, input logic [1:0] rd, ra, rb,
                              input logic [7:0] imm, res, input logic c, z);
    vec_t v;
    v.op = op; v.rd = rd; v.ra = ra; v.rb = rb; v.imm = imm;
    v.res = res; v.c = c; v.z = z;
    return v;
  endfunction

  task automatic check_reg(input string nm, input logic [1:0] idx, input logic [7:0] exp);
    dbg_addr = idx;
    #1;
    chk(nm, dbg_data, exp);
  endtask

  task automatic drive_garbage();
    cmd_valid = 1'b1;
    cmd_op    = 3'($urandom);
    cmd_rd    = 2'($urandom);
    cmd_ra    = 2'($urandom);
    cmd_rb    = 2'($urandom);
    cmd_imm   = 8'($urandom);
  endtask

  // Issue one command at a negedge; returns at the negedge after write-back (+1)
  task automatic issue(input string tag, input vec_t v, input bit hold);
    int w = 0;
    while (!cmd_ready && w < 10) begin
      @(negedge clk);
      w++;
    end
    chk({tag, ".ready_idle"}, cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op = v.op; cmd_rd = v.rd; cmd_ra = v.ra; cmd_rb = v.rb; cmd_imm = v.imm;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (hold) drive_garbage();
      else      cmd_valid = 1'b0;
      chk($sformatf("%s.busy_ready%0d", tag, k), cmd_ready, 0);
      if (k < 2) begin
        chk($sformatf("%s.early_valid%0d", tag, k), res_valid, 0);
      end else begin
        chk({tag, ".res_valid"}, res_valid, 1);
        chk({tag, ".res_data"}, res_data, v.res);
        chk({tag, ".carry"}, carry, v.c);
        chk({tag, ".zero"}, zero, v.z);
      end
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    chk({tag, ".valid_drop"}, res_valid, 0);
    chk({tag, ".ready_back"}, cmd_ready, 1);
    check_reg({tag, ".dbg_rd"}, v.rd, v.res);
  endtask

  initial begin
    int cnt;
    vecs[0]  = mk(3'd0, 2'd1, 2'd0, 2'd0, 8'hFF, 8'hFF, 1'b0, 1'b0); // LOAD r1
    vecs[1]  = mk(3'd0, 2'd2, 2'd0, 2'd0, 8'h01, 8'h01, 1'b0, 1'b0); // LOAD r2
    vecs[2]  = mk(3'd1, 2'd3, 2'd1, 2'd2, 8'h00, 8'h00, 1'b1, 1'b1); // ADD r3=r1+r2
    vecs[3]  = mk(3'd3, 2'd0, 2'd2, 2'd2, 8'h00, 8'h03, 1'b0, 1'b0); // ADC r0=r2+r2+c
    vecs[4]  = mk(3'd2, 2'd0, 2'd2, 2'd1, 8'h00, 8'h02, 1'b0, 1'b0); // SUB r2-r1
    vecs[5]  = mk(3'd2, 2'd0, 2'd1, 2'd1, 8'h00, 8'h00, 1'b1, 1'b1); // SUB r1-r1
    vecs[6]  = mk(3'd0, 2'd1, 2'd0, 2'd0, 8'h81, 8'h81, 1'b1, 1'b0); // LOAD r1, carry kept
    vecs[7]  = mk(3'd7, 2'd1, 2'd1, 2'd0, 8'h00, 8'h02, 1'b1, 1'b0); // SHL r1 (rd==ra)
    vecs[8]  = mk(3'd6, 2'd1, 2'd1, 2'd1, 8'h00, 8'h00, 1'b1, 1'b1); // XOR r1^r1
    vecs[9]  = mk(3'd0, 2'd2, 2'd0, 2'd0, 8'h3C, 8'h3C, 1'b1, 1'b0); // LOAD r2
    vecs[10] = mk(3'd0, 2'd3, 2'd0, 2'd0, 8'hF0, 8'hF0, 1'b1, 1'b0); // LOAD r3
    vecs[11] = mk(3'd4, 2'd0, 2'd2, 2'd3, 8'h00, 8'h30, 1'b1, 1'b0); // AND
    vecs[12] = mk(3'd5, 2'd0, 2'd2, 2'd3, 8'h00, 8'hFC, 1'b1, 1'b0); // OR
    vecs[13] = mk(3'd1, 2'd0, 2'd3, 2'd3, 8'h00, 8'hE0, 1'b1, 1'b0); // ADD F0+F0
    vecs[14] = mk(3'd3, 2'd1, 2'd2, 2'd2, 8'h00, 8'h79, 1'b0, 1'b0); // ADC 3C+3C+1
    vecs[15] = mk(3'd7, 2'd2, 2'd2, 2'd0, 8'h00, 8'h78, 1'b0, 1'b0); // SHL 3C
    vecs[16] = mk(3'd2, 2'd3, 2'd3, 2'd2, 8'h00, 8'h78, 1'b1, 1'b0); // SUB F0-78

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_ra = '0;
    cmd_rb = '0; cmd_imm = '0; dbg_addr = '0;
    repeat (3) @(negedge clk);
    chk("rst.ready", cmd_ready, 1);
    chk("rst.res_valid", res_valid, 0);
    chk("rst.res_data", res_data, 0);
    chk("rst.carry", carry, 0);
    chk("rst.zero", zero, 0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int r = 0; r < 4; r++) check_reg($sformatf("rst.r%0d", r), 2'(r), 8'h00);

    for (int i = 0; i < NV; i++) issue($sformatf("v%0d", i), vecs[i], 1'b0);

    // Fields churn while busy; only the accepted command may take effect
    issue("hold", mk(3'd1, 2'd0, 2'd1, 2'd3, 8'h00, 8'hF1, 1'b0, 1'b0), 1'b1);
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (res_valid) cnt++;
    end
    chk("hold.extra_results", 32'(cnt), 0);
    check_reg("hold.r1", 2'd1, 8'h79);
    check_reg("hold.r2", 2'd2, 8'h78);
    check_reg("hold.r3", 2'd3, 8'h78);
    check_reg("hold.r0", 2'd0, 8'hF1);

    // Reset asserted while ADD r3 = r1 + r2 is in EXEC
    cmd_valid = 1'b1; cmd_op = 3'd1; cmd_rd = 2'd3; cmd_ra = 2'd1; cmd_rb = 2'd2;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid.ready", cmd_ready, 1);
    chk("mid.res_valid", res_valid, 0);
    chk("mid.res_data", res_data, 0);
    chk("mid.carry", carry, 0);
    chk("mid.zero", zero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (res_valid) cnt++;
    end
    chk("mid.no_result", 32'(cnt), 0);
    for (int r = 0; r < 4; r++) check_reg($sformatf("mid.r%0d", r), 2'(r), 8'h00);

    issue("post", mk(3'd0, 2'd2, 2'd0, 2'd0, 8'h55, 8'h55, 1'b0, 1'b0), 1'b0);
    issue("post2", mk(3'd1, 2'd0, 2'd2, 2'd2, 8'h00, 8'hAA, 1'b0, 1'b0), 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_regfile_seq.md
# alu_regfile_seq

Parametrised successor to the two-register ALU datapath. It replaces the fixed A/B register pair and the 1-bit add/sub select with a NUM_REGS-entry register file, an 8-operation ALU and registered carry/zero flags. A small sequencer FSM executes one command per transaction through a valid/ready handshake. It sits between the instruction decoder and the register-level datapath of the microprocessor.

## Interface
Parameters:
- BIT_WIDTH, 8, datapath width in bits (>= 2)
- NUM_REGS, 4, register-file depth (power of 2, >= 2); ADDR_W = clog2(NUM_REGS), local

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_op  in  3  operation code
- cmd_rd, cmd_ra, cmd_rb  in  ADDR_W each  destination and source register indices
- cmd_imm  in  BIT_WIDTH  immediate for LOAD
- res_valid  out  1  one-cycle strobe: result and flags valid
- res_data  out  BIT_WIDTH  registered result
- carry, zero  out  1 each  registered flags
- dbg_addr  in  ADDR_W  debug read index
- dbg_data  out  BIT_WIDTH  combinational read of regfile[dbg_addr]

## Operation
- Opcodes:
  - 000 LOAD: rd = imm
  - 001 ADD: rd = ra + rb
  - 010 SUB: rd = ra - rb
  - 011 ADC: rd = ra + rb + carry
  - 100 AND
  - 101 OR
  - 110 XOR
  - 111 SHL: rd = ra << 1, LSB = 0
- Arithmetic is computed at BIT_WIDTH+1 bits and wraps modulo 2^BIT_WIDTH.
- Carry flag:
  - ADD/ADC: bit BIT_WIDTH of the sum.
  - SUB: NOT borrow, i.e. 1 when ra >= rb unsigned.
  - SHL: old MSB of ra.
  - LOAD and logic ops: carry unchanged.
- Zero flag = (result == 0). It is updated by every opcode, including LOAD.
- FSM states and transitions:
  - IDLE: cmd_ready = 1. On cmd_valid & cmd_ready, latch op/rd/ra/rb/imm and go to READ.
  - READ: latch regfile[ra] and regfile[rb] into operand registers, go to EXEC.
  - EXEC: compute, latch res_data, carry and zero, go to WB.
  - WB: res_valid = 1, write regfile[rd] = res_data, go to IDLE.
- Command fields are sampled only at the accepting edge. cmd_valid and field changes outside IDLE are ignored.
- Operands are snapshotted in READ, so rd equal to ra and/or rb is legal and uses pre-write values.
- ADC uses the carry value present at the start of EXEC, i.e. the previous command's carry.
- There is no result backpressure; res_valid is a pure strobe.
- cmd_ready is decoded from state: high in IDLE only.

## Timing
- Handshake at edge E0. Then:
  - E1: operands latched.
  - E2: res_data, carry and zero update. res_valid goes high for the E2–E3 cycle only.
  - E3: regfile[rd] written; cmd_ready returns high.
- Latency from accept to res_valid is 2 cycles. Throughput is one command per 4 cycles.
- A new command can be accepted at E4 at the earliest.
- dbg_data shows the new rd value from E3 onward.
- Reset (rst_n low, asynchronous) forces:
  - state = IDLE, cmd_ready = 1
  - all regfile entries = 0
  - res_data = 0, res_valid = 0, carry = 0, zero = 0
- Reset asserted mid-command, in any state, discards the command. No regfile write occurs after reset assertion. Release returns to IDLE.

## Test plan
- Reset, then LOAD r1 = 0xFF and LOAD r2 = 0x01 (BIT_WIDTH = 8) -> res_valid exactly 2 cycles after each accept; dbg r1 = 0xFF, r2 = 0x01; zero = 0.
- ADD r3 = r1 + r2 -> res_data 0x00, carry 1, zero 1. Then ADC r0 = r2 + r2 -> 0x03, carry 0.
- SUB r0 = r2 - r1 -> 0x02, carry 0. SUB r0 = r1 - r1 -> 0x00, carry 1, zero 1.
- LOAD r1 = 0x81, then SHL r1 = r1 << 1 (rd == ra) -> 0x02, carry 1. Then XOR r1 = r1 ^ r1 -> 0x00, zero 1, carry still 1.
- cmd_valid held high with changing fields during READ/EXEC/WB -> cmd_ready 0, fields ignored, exactly one result per accepted command, next accept no earlier than 4 cycles after the previous.
- rst_n pulsed low during EXEC of ADD r3 -> no res_valid; all regs, flags and res_data read 0; cmd_ready 1 immediately.
